// File: rtl/scytale_encryption.sv
// Scytale transposition encoder.
// Collects plaintext bytes until TERMINATOR, then emits them column-wise
// (column outer, row inner) followed by TERMINATOR.
// Optional build macro SCYTALE_PAD_EN: slots beyond the message length emit
// PAD_CHAR instead of leaving a valid_o=0 gap.
module scytale_encryption #(
    parameter int                 D_WIDTH    = 8,
    parameter int                 KEY_WIDTH  = 8,
    parameter int                 MAX_CHARS  = 50,
    parameter logic [D_WIDTH-1:0] TERMINATOR = 8'hFA,
    parameter logic [D_WIDTH-1:0] PAD_CHAR   = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy,
    output logic                 error
);

    localparam int LW = $clog2(MAX_CHARS + 1);
    localparam int PW = 2 * KEY_WIDTH;

`ifdef SCYTALE_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        COLLECT,
        EMIT,
        TERM,
        FINISH
    } state_t;

    state_t               state_q;
    logic [LW-1:0]        len_q;
    logic                 ovf_q;
    logic [KEY_WIDTH-1:0] n_q, m_q;
    logic [KEY_WIDTH-1:0] col_q, row_q;
    logic [PW-1:0]        idx_q;
    logic [D_WIDTH-1:0]   data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 error_q;
    logic [D_WIDTH-1:0]   buf_q [MAX_CHARS];

    // Slot currently being emitted and the one after it
    logic [KEY_WIDTH-1:0] cur_n, cur_m, cur_col, cur_row;
    logic [PW-1:0]        cur_idx;
    logic [KEY_WIDTH-1:0] col_d, row_d;
    logic [PW-1:0]        idx_d;
    logic                 last_slot;
    logic                 hit;
    logic                 emit_valid;
    logic [D_WIDTH-1:0]   emit_data;
    logic [PW-1:0]        area;
    logic                 msg_bad;
    logic                 store_byte;

    // Current slot: first slot comes straight from the keys on terminator accept
    always_comb begin
        if (state_q == COLLECT) begin
            cur_n   = key_N;
            cur_m   = key_M;
            cur_col = '0;
            cur_row = '0;
            cur_idx = '0;
        end else begin
            cur_n   = n_q;
            cur_m   = m_q;
            cur_col = col_q;
            cur_row = row_q;
            cur_idx = idx_q;
        end

        last_slot = (cur_col == cur_n - KEY_WIDTH'(1)) && (cur_row == cur_m - KEY_WIDTH'(1));

        // idx advances by N down a column and restarts at the new column index
        if (cur_row == cur_m - KEY_WIDTH'(1)) begin
            row_d = '0;
            col_d = cur_col + KEY_WIDTH'(1);
            idx_d = PW'(cur_col) + PW'(1);
        end else begin
            row_d = cur_row + KEY_WIDTH'(1);
            col_d = cur_col;
            idx_d = cur_idx + PW'(cur_n);
        end

        hit        = cur_idx < PW'(len_q);
        emit_valid = hit | PAD_EN;
        if (hit) begin
            emit_data = buf_q[cur_idx[LW-1:0]];
        end else if (PAD_EN) begin
            emit_data = PAD_CHAR;
        end else begin
            emit_data = data_q;
        end
    end

    // Message acceptance checks evaluated on the terminator cycle
    always_comb begin
        area       = PW'(key_N) * PW'(key_M);
        msg_bad    = (key_N == '0) || (key_M == '0) || ovf_q || (PW'(len_q) > area);
        store_byte = (state_q == COLLECT) && valid_i && (data_i != TERMINATOR)
                     && (len_q < LW'(MAX_CHARS));
    end

    // Plaintext buffer write; contents need no reset
    always_ff @(posedge clk) begin
        if (store_byte) begin
            buf_q[len_q] <= data_i;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            n_q     <= '0;
            m_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
        end else begin
            error_q <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (valid_i) begin
                        if (data_i != TERMINATOR) begin
                            if (len_q < LW'(MAX_CHARS)) begin
                                len_q <= len_q + LW'(1);
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else if (msg_bad) begin
                            error_q <= 1'b1;
                            len_q   <= '0;
                            ovf_q   <= 1'b0;
                        end else begin
                            n_q     <= key_N;
                            m_q     <= key_M;
                            busy_q  <= 1'b1;
                            valid_q <= emit_valid;
                            data_q  <= emit_data;
                            col_q   <= col_d;
                            row_q   <= row_d;
                            idx_q   <= idx_d;
                            state_q <= last_slot ? TERM : EMIT;
                        end
                    end
                end
                EMIT: begin
                    valid_q <= emit_valid;
                    data_q  <= emit_data;
                    col_q   <= col_d;
                    row_q   <= row_d;
                    idx_q   <= idx_d;
                    if (last_slot) begin
                        state_q <= TERM;
                    end
                end
                TERM: begin
                    valid_q <= 1'b1;
                    data_q  <= TERMINATOR;
                    state_q <= FINISH;
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    len_q   <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= COLLECT;
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy    = busy_q;
    assign error   = error_q;

endmodule

// File: tb/tb_scytale_encryption.sv
// Self-checking bench for scytale_encryption with a column/row reference model.
module tb_scytale_encryption;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N, key_M;
    logic [7:0] data_o;
    logic       valid_o, busy, error;

`ifdef SCYTALE_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] msg_q[$];
    logic [7:0] mdl_last;

    scytale_encryption dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .valid_i(valid_i),
        .key_N  (key_N),
        .key_M  (key_M),
        .data_o (data_o),
        .valid_o(valid_o),
        .busy   (busy),
        .error  (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'hFA) b = 8'($urandom);
        return b;
    endfunction

    // Feed plaintext with random idle cycles, then the terminator with keys
    task automatic send_msg(input int n, input int m);
        foreach (msg_q[i]) begin
            valid_i = 1'b1;
            data_i  = msg_q[i];
            tick();
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                data_i  = 8'($urandom);
                tick();
            end
        end
        valid_i = 1'b1;
        data_i  = 8'hFA;
        key_N   = 8'(n);
        key_M   = 8'(m);
        tick();
        valid_i = 1'b0;
        key_N   = 8'($urandom);
        key_M   = 8'($urandom);
    endtask

    // Send one message and check the whole response cycle by cycle
    task automatic run_message(input int n, input int m, input bit junk, input string nm);
        int         len;
        bit         bad;
        bit         ev_v[$];
        logic [7:0] ev_d[$];
        logic [10:0] exp_o;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
        len = msg_q.size();
        bad = (n == 0) || (m == 0) || (len > 50) || (len > n * m);
        for (int c = 0; c < n; c++) begin
            for (int r = 0; r < m; r++) begin
                int idx;
                idx = r * n + c;
                if (idx < len) begin
                    ev_v.push_back(1'b1);
                    ev_d.push_back(msg_q[idx]);
                end else begin
                    ev_v.push_back(PAD_EN);
                    ev_d.push_back(8'h20);
                end
            end
        end
        send_msg(n, m);
        if (bad) begin
            n_cmp++;
            if ({valid_o, busy, error} !== 3'b001) begin
                n_bad++;
                $display("FAIL %s err_pulse: got v/b/e=%b%b%b want 001", nm, valid_o, busy, error);
            end
            tick();
            n_cmp++;
            if ({valid_o, busy, error} !== 3'b000) begin
                n_bad++;
                $display("FAIL %s err_after: got v/b/e=%b%b%b want 000", nm, valid_o, busy, error);
            end
        end else begin
            for (int k = 0; k <= n * m + 1; k++) begin
                if (k < n * m) begin
                    ev = ev_v[k];
                    ed = ev ? ev_d[k] : mdl_last;
                    eb = 1'b1;
                end else if (k == n * m) begin
                    ev = 1'b1;
                    ed = 8'hFA;
                    eb = 1'b1;
                end else begin
                    ev = 1'b0;
                    ed = mdl_last;
                    eb = 1'b0;
                end
                if (ev) mdl_last = ed;
                exp_o = {ev, eb, 1'b0, ed};
                n_cmp++;
                if ({valid_o, busy, error, data_o} !== exp_o) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got v/b/e=%b%b%b d=%h want v/b/e=%b%b0 d=%h",
                             nm, k, valid_o, busy, error, data_o, ev, eb, ed);
                end
                if (k <= n * m) begin
                    valid_i = junk;
                    data_i  = junk ? 8'($urandom) : 8'h00;
                end
                if (k < n * m + 1) tick();
            end
            valid_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        key_N   = 8'h00;
        key_M   = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        mdl_last = 8'h00;
        n_cmp++;
        if ({valid_o, busy, error, data_o} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset: got v/b/e=%b%b%b d=%h want 000 d=00", valid_o, busy, error, data_o);
        end
    endtask

    task automatic test_basic();
        load("ABCDEF"); run_message(3, 2, 1'b0, "abcdef_3x2");
        load("ABCDE");  run_message(3, 2, 1'b0, "abcde_3x2");
        load("Q");      run_message(1, 1, 1'b0, "single_1x1");
    endtask

    task automatic test_errors();
        load("HELLO"); run_message(0, 4, 1'b0, "keyN_zero");
        load("AB");    run_message(2, 1, 1'b0, "ab_after_err");
        load("AB");    run_message(3, 0, 1'b0, "keyM_zero");
        msg_q.delete();
        for (int i = 0; i < 51; i++) msg_q.push_back(rand_byte());
        run_message(8, 8, 1'b0, "overflow51");
        load("ABCDEFG"); run_message(2, 3, 1'b0, "len_gt_area");
        msg_q.delete();
        for (int i = 0; i < 50; i++) msg_q.push_back(rand_byte());
        run_message(10, 5, 1'b0, "full50_10x5");
    endtask

    task automatic test_empty();
        msg_q.delete();
        run_message(2, 2, 1'b0, "empty_2x2");
    endtask

    task automatic test_back_to_back();
        load("ABCDEF"); run_message(3, 2, 1'b1, "junk_during_emit");
        load("QRS");    run_message(2, 2, 1'b0, "after_junk");
    endtask

    task automatic test_reset_mid_emit();
        load("ABCDEF");
        send_msg(3, 2);
        n_cmp++;
        if ({valid_o, busy, data_o} !== {2'b11, 8'h41}) begin
            n_bad++;
            $display("FAIL rst_mid slot0: got v/b=%b%b d=%h want 11 d=41", valid_o, busy, data_o);
        end
        tick();
        n_cmp++;
        if ({valid_o, busy, data_o} !== {2'b11, 8'h44}) begin
            n_bad++;
            $display("FAIL rst_mid slot1: got v/b=%b%b d=%h want 11 d=44", valid_o, busy, data_o);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_last = 8'h00;
        n_cmp++;
        if ({valid_o, busy, error, data_o} !== 11'b0) begin
            n_bad++;
            $display("FAIL rst_mid after: got v/b/e=%b%b%b d=%h want 000 d=00", valid_o, busy, error, data_o);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if ({valid_o, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL rst_mid quiet %0d: got v/b=%b%b want 00", k, valid_o, busy);
            end
        end
        load("XY"); run_message(1, 2, 1'b0, "xy_after_rst");
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            int n, m, len, cap;
            n   = $urandom_range(1, 9);
            m   = $urandom_range(1, 9);
            cap = (n * m < 50) ? n * m : 50;
            len = $urandom_range(0, cap);
            if ($urandom_range(0, 5) == 0 && n * m < 50) len = n * m + 1;
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(rand_byte());
            run_message(n, m, 1'($urandom_range(0, 1)), $sformatf("rand%0d_%0dx%0d_L%0d", t, n, m, len));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_empty();
        test_back_to_back();
        test_reset_mid_emit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
